fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit_imem_rom.sv | 23 ++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction size, NOP encoding, IF/ID bundle layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Field width of the IF/ID bundle at the default 32-bit datapath.
    localparam int IFID_XLEN = 32;

    // IF/ID pipeline bundle: PC+4 of the fetched instruction, the word itself, and a
    // valid flag that is low for a bubble.
    typedef struct packed {
        logic [IFID_XLEN-1:0] pc;
        logic [IFID_XLEN-1:0] instr;
        logic                 valid;
    } ifid_t;

endpackage

// File: rtl/fetch_unit_imem_rom.sv
// Instruction ROM with a purely combinational read port, indexed by word.
// Latency: zero cycles (address to data is combinational).
// Backpressure: none; the word at addr_i is always presented on rdata_o.
module imem_rom #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic [$clog2(IMEM_DEPTH)-1:0] addr_i,
    output logic [XLEN-1:0]               rdata_o
);

    // Fixed index-tagged image: every word carries its own index in the low bits,
    // so any fetch from the wrong slot is visible in the returned word.
    function automatic logic [XLEN-1:0] image_word(input logic [$clog2(IMEM_DEPTH)-1:0] a);
        return XLEN'(32'hC0DE_0000) | XLEN'(a);
    endfunction

    // Combinational read of the addressed word.
    always_comb begin
        rdata_o = image_word(addr_i);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational ROM read, registered IF/ID outputs.
// Latency: one cycle PC -> IF/ID; a redirect shows its first valid instruction two edges later.
// Backpressure: stall freezes PC and IF/ID; br_taken flushes (valid=0) even while stalled.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt / stall_cnt outputs.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 1024,
    parameter int              OFFSET_W   = 16,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [XLEN-1:0]     br_base,
    input  logic [OFFSET_W-1:0] br_offset,
    output logic [XLEN-1:0]     if_pc,
    output logic [XLEN-1:0]     if_instr,
    output logic                if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    import fetch_pkg::*;

    localparam int AW = $clog2(IMEM_DEPTH);

    // IF/ID bundle at this instance's datapath width (same layout as ifid_t).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_w_t;

    logic [XLEN-1:0] pc_q, pc_d;
    ifid_w_t         ifid_q, ifid_d;

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] off_sx;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] imem_rdata;
    logic [AW-1:0]   imem_idx;
    logic            load_fetch;

    // Only the word-index bits address the ROM; the rest of the PC wraps away.
    assign imem_idx = pc_q[AW+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_q[XLEN-1:AW+2], pc_q[1:0]};

    imem_rom #(
        .XLEN       (XLEN),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_imem (
        .addr_i  (imem_idx),
        .rdata_o (imem_rdata)
    );

    // Sequential and redirect address arithmetic; both wrap modulo 2^XLEN.
    always_comb begin
        pc_seq    = pc_q + XLEN'(INSTR_BYTES);
        off_sx    = {{(XLEN-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};
        br_target = br_base + (off_sx << 2);
    end

    // Next-state selection: redirect beats stall, stall beats a normal fetch.
    always_comb begin
        pc_d       = pc_q;
        ifid_d     = ifid_q;
        load_fetch = 1'b0;
        if (br_taken) begin
            // Flush: only the valid bit matters, pc/instr simply hold.
            pc_d         = br_target;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            load_fetch   = 1'b1;
            pc_d         = pc_seq;
            ifid_d.pc    = pc_seq;
            ifid_d.instr = imem_rdata;
            ifid_d.valid = 1'b1;
        end
    end

    // PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_q.pc    <= '0;
            ifid_q.instr <= XLEN'(NOP_INSTR);
            ifid_q.valid <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign if_pc    = ifid_q.pc;
    assign if_instr = ifid_q.instr;
    assign if_valid = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters: valid loads, and stalls that were not flushed.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_fetch && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall && !br_taken && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared with the rest of the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_load_fetch;
    assign unused_load_fetch = load_fetch;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors push expected IF/ID state per edge,
// an independent monitor pops one entry per edge and compares.
// Runs with IMEM_DEPTH=16 so index wrap is reachable; counters checked when enabled.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_base;
    logic [15:0] br_offset;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .IMEM_DEPTH (16),
        .OFFSET_W   (16),
        .RESET_PC   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_base   (br_base),
        .br_offset (br_offset),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_valid  (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        string       nm;
        bit          ev;
        bit          cd;
        logic [31:0] pc;
        logic [31:0] ins;
        bit          cc;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];

    // Known ROM image: word i holds 0xC0DE0000 | i.
    function automatic logic [31:0] m(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic step(input string nm, input bit r, input bit s, input bit b,
                        input logic [31:0] base, input logic [15:0] off,
                        input bit ev, input bit cd, input logic [31:0] epc,
                        input logic [31:0] eins, input bit cc,
                        input logic [31:0] efc, input logic [31:0] esc);
        exp_t e;
        rst       = r;
        stall     = s;
        br_taken  = b;
        br_base   = base;
        br_offset = off;
        e.nm = nm; e.ev = ev; e.cd = cd; e.pc = epc; e.ins = eins;
        e.cc = cc; e.fc = efc; e.sc = esc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nrm(input string nm, input logic [31:0] epc, input int mi);
        step(nm, 0, 0, 0, 32'h0, 16'h0, 1, 1, epc, m(mi), 0, 0, 0);
    endtask

    task automatic do_rst(input string nm, input bit s, input bit b);
        step(nm, 1, s, b, 32'h40, 16'h1, 0, 1, 32'h0, 32'h0, 1, 0, 0);
    endtask

    task automatic br(input string nm, input bit s, input logic [31:0] base,
                      input logic [15:0] off);
        step(nm, 0, s, 1, base, off, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one scoreboard entry per active edge, sampled 2 time units after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (if_valid !== e.ev) begin
                    errors++;
                    $display("FAIL %s if_valid got %0b want %0b", e.nm, if_valid, e.ev);
                end
                if (e.cd) begin
                    checks++;
                    if (if_pc !== e.pc) begin
                        errors++;
                        $display("FAIL %s if_pc got %h want %h", e.nm, if_pc, e.pc);
                    end
                    checks++;
                    if (if_instr !== e.ins) begin
                        errors++;
                        $display("FAIL %s if_instr got %h want %h", e.nm, if_instr, e.ins);
                    end
                end
`ifdef FETCH_PERF_CNT_EN
                if (e.cc) begin
                    checks++;
                    if (fetch_cnt !== e.fc) begin
                        errors++;
                        $display("FAIL %s fetch_cnt got %0d want %0d", e.nm, fetch_cnt, e.fc);
                    end
                    checks++;
                    if (stall_cnt !== e.sc) begin
                        errors++;
                        $display("FAIL %s stall_cnt got %0d want %0d", e.nm, stall_cnt, e.sc);
                    end
                end
`endif
            end
        end
    end

    // Directed stimulus.
    initial begin
        // Reset for two cycles, then free-run four fetches.
        do_rst("rst0", 0, 0);
        do_rst("rst1", 0, 0);
        nrm("seq0", 32'd4, 0);
        nrm("seq1", 32'd8, 1);
        nrm("seq2", 32'd12, 2);
        nrm("seq3", 32'd16, 3);

        // Reset overrides a simultaneous stall and redirect, leaving no residue.
        do_rst("rst_over", 1, 1);
        nrm("post_rst0", 32'd4, 0);
        nrm("post_rst1", 32'd8, 1);
        nrm("post_rst2", 32'd12, 2);

        // Three stall cycles hold the PC=8 fetch, then PC=12 is fetched.
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 0, 1, 0, 0, 0, 1, 1, 32'd12, m(2), 0, 0, 0);
        end
        nrm("after_stall", 32'd16, 3);

        // Backward branch: 0x10 + (-2 << 2) = 0x08.
        br("br_neg", 0, 32'h10, 16'hFFFE);
        nrm("br_neg_tgt", 32'h0C, 2);
        nrm("br_neg_next", 32'h10, 3);

        // Branch during stall: flush wins, target 0x20 + 12 = 0x2C (index 11).
        br("br_stall", 1, 32'h20, 16'd3);
        step("stall_bubble", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nrm("br_stall_tgt", 32'h30, 11);

        // Index wrap: PC=0x40 reads word 0 of a 16-word ROM.
        br("br_40", 0, 32'h40, 16'h0);
        nrm("wrap_idx", 32'h44, 0);

        // PC wrap: 0x0 + (-1 << 2) = 0xFFFFFFFC; next sequential PC is 0.
        br("br_top", 0, 32'h0, 16'hFFFF);
        nrm("wrap_pc", 32'h0, 15);
        nrm("wrap_next", 32'h4, 0);

        // Largest positive offset: 0x100 + 0x1FFFC = 0x200FC (index 15).
        br("br_pos", 0, 32'h100, 16'h7FFF);
        nrm("br_pos_tgt", 32'h20100, 15);

        // Counters: 10 fetches, 3 stalls, 1 branch after reset.
        do_rst("cnt_rst", 0, 0);
        for (int i = 0; i < 10; i++) begin
            nrm("cnt_run", 32'(4 * (i + 1)), i);
        end
        for (int i = 0; i < 3; i++) begin
            step("cnt_stall", 0, 1, 0, 0, 0, 1, 1, 32'd40, m(9), 0, 0, 0);
        end
        step("cnt_br", 0, 0, 1, 32'h0, 16'h0, 0, 0, 0, 0, 1, 32'd10, 32'd3);
        step("cnt_more", 0, 0, 0, 0, 0, 1, 1, 32'd4, m(0), 1, 32'd11, 32'd3);
        do_rst("cnt_clear", 0, 0);
        step("cnt_restart", 0, 0, 0, 0, 0, 1, 1, 32'd4, m(0), 1, 32'd1, 32'd0);

        // Let the monitor drain the last entry, then confirm nothing is left over.
        rst      = 1'b0;
        stall    = 1'b1;
        br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
